branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Consumer side of the N/Z/V flag interface: reads the architectural flags written by the flag register and resolves conditional branches for the 16-bit core.
- Evaluates the 3-bit condition code against the flags and computes the branch target (PC-relative B or register BR).
- Stalls decode while a flag-writing ALU op is still in flight, issues a one-cycle redirect/flush when taken, and keeps a saturating taken-branch counter.

Parameters:
- WIDTH, 16, PC/register width
- IMM_W, 9, signed branch offset width, in halfwords
- CNT_W, 16, taken-branch counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  branch instruction present in decode this cycle
- br_is_reg  in  1  1 = BR (target from br_reg), 0 = B (PC-relative)
- br_cond  in  3  condition code
- br_imm  in  IMM_W  signed offset in halfwords
- br_reg  in  WIDTH  register-source target
- pc_plus2  in  WIDTH  address of branch + 2
- flag_pend  in  1  flag-writing op ahead in pipe; flags not yet final
- N_flag, Z_flag, V_flag  in  1 each  architectural flags (valid when flag_pend=0)
- stall  out  1  hold fetch/decode
- redirect  out  1  one-cycle taken pulse
- flush  out  1  squash fetch/decode wrong-path instruction (== redirect)
- pc_target  out  WIDTH  redirect address, meaningful when redirect=1
- taken_cnt  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset: state=IDLE. stall, redirect, flush, pc_target, taken_cnt and the latched branch fields are all 0.
- Reset asserted mid-operation (HOLD or REDIRECT) aborts immediately; no redirect pulse is emitted afterwards.
- Condition table (cond: taken when):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 UN: always
- Target computation:
  - B: pc_plus2 + (sign-extend(br_imm) << 1), modulo 2^WIDTH; wrap-around is silent.
  - BR: br_reg.
- FSM states: IDLE, HOLD, REDIRECT. Outputs are registered.
  - stall = (state==HOLD).
  - redirect = flush = (state==REDIRECT).
  - pc_target is held from the latch.
- IDLE:
  - br_valid=0: stay IDLE.
  - br_valid=1, flag_pend=1: latch br_is_reg, br_cond, br_imm, br_reg, pc_plus2; go to HOLD.
  - br_valid=1, flag_pend=0: evaluate with the current flags. Taken: latch target, go to REDIRECT. Not taken: stay IDLE. No stall, no redirect.
- HOLD:
  - flag_pend=1: stay HOLD. Upstream keeps br_* stable but the unit uses only latched copies.
  - flag_pend=0: evaluate latched cond against the current flags. Taken: go to REDIRECT. Not taken: go to IDLE.
- REDIRECT: lasts exactly 1 cycle, then IDLE. br_valid during REDIRECT is wrong-path and ignored.
- Latency:
  - No hazard: br_valid in cycle N gives redirect in N+1.
  - Hazard: stall is high from N+1 until the cycle after flag_pend first samples low. Redirect follows in the next cycle.
- taken_cnt increments by 1 on every entry to REDIRECT and saturates at 2^CNT_W-1, never wrapping.
- Unconditional (111) branches still wait in HOLD if flag_pend=1; ordering is kept simple.
- X on br_* while br_valid=0 must not affect state.

Test Plan:
- Reset, then B EQ with Z=1, br_imm=9'h004, pc_plus2=16'h0100, flag_pend=0 -> next cycle redirect=flush=1, pc_target=16'h0108 for exactly one cycle; taken_cnt=1.
- B NE with Z=1 -> no redirect, stall stays 0, taken_cnt unchanged. Repeat all 8 conds over all 8 NZV combinations, checking against the table.
- br_valid with flag_pend=1 for 3 cycles, GT, flags then N=0 Z=0 -> stall high 3 cycles, then one cycle with redirect=1. Same with Z=1 -> stall drops, no redirect.
- B with br_imm=9'h1FF (-1), pc_plus2=16'h0000 -> pc_target=16'hFFFE (wrap). BR UN with br_reg=16'hBEEF -> pc_target=16'hBEEF.
- rst pulsed while in HOLD and while redirect=1 -> all outputs 0 asynchronously, no pulse after release. br_valid asserted during REDIRECT -> ignored.
- CNT_W=4, 17 taken branches -> taken_cnt stops at 4'hF.

Source files
------------

// File: rtl/branch_cond_unit.sv
// Branch condition unit: resolves conditional branches against the N/Z/V
// flags, stalls decode while flags are pending, and issues a one-cycle
// redirect/flush with the computed target. Also counts taken branches.
module branch_cond_unit #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic             br_is_reg,
    input  logic [2:0]       br_cond,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [WIDTH-1:0] br_reg,
    input  logic [WIDTH-1:0] pc_plus2,
    input  logic             flag_pend,
    input  logic             N_flag,
    input  logic             Z_flag,
    input  logic             V_flag,
    output logic             stall,
    output logic             redirect,
    output logic             flush,
    output logic [WIDTH-1:0] pc_target,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t             state_q;
    logic               stall_q;
    logic               redirect_q;
    logic [WIDTH-1:0]   pc_target_q;
    logic [CNT_W-1:0]   cnt_q;

    // Latched branch fields, used while waiting in HOLD
    logic               is_reg_q;
    logic [2:0]         cond_q;
    logic [IMM_W-1:0]   imm_q;
    logic [WIDTH-1:0]   reg_q;
    logic [WIDTH-1:0]   pc_q;

    // Evaluation inputs and results
    logic               sel_is_reg;
    logic [2:0]         sel_cond;
    logic [IMM_W-1:0]   sel_imm;
    logic [WIDTH-1:0]   sel_reg;
    logic [WIDTH-1:0]   sel_pc;
    logic [WIDTH-1:0]   sext_imm;
    logic               taken_d;
    logic [WIDTH-1:0]   target_d;
    logic [CNT_W-1:0]   cnt_d;

    function automatic logic cond_taken(input logic [2:0] cond,
                                        input logic n, input logic z,
                                        input logic v);
        logic t;
        case (cond)
            3'b000:  t = ~z;                  // NE
            3'b001:  t = z;                   // EQ
            3'b010:  t = ~z & ~n;             // GT
            3'b011:  t = n;                   // LT
            3'b100:  t = z | (~z & ~n);       // GE
            3'b101:  t = n | z;               // LE
            3'b110:  t = v;                   // OV
            default: t = 1'b1;                // UN
        endcase
        return t;
    endfunction

    // Select live or latched branch fields, evaluate condition and target
    always_comb begin
        if (state_q == HOLD) begin
            sel_is_reg = is_reg_q;
            sel_cond   = cond_q;
            sel_imm    = imm_q;
            sel_reg    = reg_q;
            sel_pc     = pc_q;
        end else begin
            sel_is_reg = br_is_reg;
            sel_cond   = br_cond;
            sel_imm    = br_imm;
            sel_reg    = br_reg;
            sel_pc     = pc_plus2;
        end
        sext_imm = {{(WIDTH-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
        taken_d  = cond_taken(sel_cond, N_flag, Z_flag, V_flag);
        if (sel_is_reg)
            target_d = sel_reg;
        else
            target_d = sel_pc + {sext_imm[WIDTH-2:0], 1'b0};
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Branch FSM with registered stall/redirect/target and taken counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stall_q     <= 1'b0;
            redirect_q  <= 1'b0;
            pc_target_q <= '0;
            cnt_q       <= '0;
            is_reg_q    <= 1'b0;
            cond_q      <= '0;
            imm_q       <= '0;
            reg_q       <= '0;
            pc_q        <= '0;
        end else begin
            stall_q    <= 1'b0;
            redirect_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (br_valid) begin
                        is_reg_q <= br_is_reg;
                        cond_q   <= br_cond;
                        imm_q    <= br_imm;
                        reg_q    <= br_reg;
                        pc_q     <= pc_plus2;
                        if (flag_pend) begin
                            state_q <= HOLD;
                            stall_q <= 1'b1;
                        end else if (taken_d) begin
                            state_q     <= REDIRECT;
                            redirect_q  <= 1'b1;
                            pc_target_q <= target_d;
                            cnt_q       <= cnt_d;
                        end
                    end
                end
                HOLD: begin
                    if (flag_pend) begin
                        stall_q <= 1'b1;
                    end else if (taken_d) begin
                        state_q     <= REDIRECT;
                        redirect_q  <= 1'b1;
                        pc_target_q <= target_d;
                        cnt_q       <= cnt_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REDIRECT: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign stall     = stall_q;
    assign redirect  = redirect_q;
    assign flush     = redirect_q;
    assign pc_target = pc_target_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: vector table, full cond/flag sweep,
// hazard stalls, asynchronous reset aborts and counter saturation.
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_is_reg, flag_pend, N_flag, Z_flag, V_flag;
    logic [2:0]  br_cond;
    logic [8:0]  br_imm;
    logic [15:0] br_reg, pc_plus2;
    logic        stall, redirect, flush;
    logic [15:0] pc_target, taken_cnt;
    logic        stall4, redirect4, flush4;
    logic [15:0] pc_target4;
    logic [3:0]  taken_cnt4;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.WIDTH(16), .IMM_W(9), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg),
        .br_cond(br_cond), .br_imm(br_imm), .br_reg(br_reg), .pc_plus2(pc_plus2),
        .flag_pend(flag_pend), .N_flag(N_flag), .Z_flag(Z_flag), .V_flag(V_flag),
        .stall(stall), .redirect(redirect), .flush(flush),
        .pc_target(pc_target), .taken_cnt(taken_cnt)
    );

    branch_cond_unit #(.WIDTH(16), .IMM_W(9), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg),
        .br_cond(br_cond), .br_imm(br_imm), .br_reg(br_reg), .pc_plus2(pc_plus2),
        .flag_pend(flag_pend), .N_flag(N_flag), .Z_flag(Z_flag), .V_flag(V_flag),
        .stall(stall4), .redirect(redirect4), .flush(flush4),
        .pc_target(pc_target4), .taken_cnt(taken_cnt4)
    );

    typedef struct {
        logic        is_reg;
        logic [2:0]  cond;
        logic [8:0]  imm;
        logic [15:0] breg;
        logic [15:0] pc;
        logic [2:0]  nzv;
        logic        exp_taken;
        logic [15:0] exp_target;
    } vec_t;

    typedef struct {
        logic [2:0] cond;
        logic [7:0] mask;   // bit {N,Z,V} set when taken
    } cmask_t;

    vec_t   vecs [8];
    cmask_t cmasks [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, ".cnt"}, {16'd0, taken_cnt}, exp_cnt);
        chk({name, ".cnt4"}, {28'd0, taken_cnt4}, (exp_cnt > 15) ? 15 : exp_cnt);
    endtask

    // Single no-hazard branch: decode in cycle N, redirect (if any) in N+1
    task automatic do_branch(input string name, input logic is_reg, input logic [2:0] cond,
                             input logic [8:0] imm, input logic [15:0] breg,
                             input logic [15:0] pc, input logic [2:0] nzv,
                             input logic exp_taken, input logic [15:0] exp_target);
        br_valid  = 1'b1;
        br_is_reg = is_reg;
        br_cond   = cond;
        br_imm    = imm;
        br_reg    = breg;
        pc_plus2  = pc;
        {N_flag, Z_flag, V_flag} = nzv;
        flag_pend = 1'b0;
        step();
        br_valid  = 1'b0;
        br_is_reg = 1'bx;
        br_cond   = 'x;
        br_imm    = 'x;
        br_reg    = 'x;
        pc_plus2  = 'x;
        chk({name, ".stall"}, {31'd0, stall}, 0);
        if (exp_taken) begin
            exp_cnt++;
            chk({name, ".redirect"}, {31'd0, redirect}, 1);
            chk({name, ".flush"}, {31'd0, flush}, 1);
            chk({name, ".target"}, {16'd0, pc_target}, {16'd0, exp_target});
        end else begin
            chk({name, ".redirect"}, {31'd0, redirect}, 0);
        end
        chk_cnt(name);
        step();
        chk({name, ".pulse_end"}, {30'd0, redirect, flush}, 0);
    endtask

    // Branch decoded while flags pending: stall for hold cycles, then resolve
    task automatic hazard(input string name, input logic [2:0] cond, input int hold,
                          input logic [2:0] nzv, input logic exp_taken);
        br_valid  = 1'b1;
        br_is_reg = 1'b0;
        br_cond   = cond;
        br_imm    = 9'h1F0;          // -16 halfwords
        br_reg    = 16'h5555;
        pc_plus2  = 16'h0200;
        {N_flag, Z_flag, V_flag} = ~nzv;
        flag_pend = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            br_valid = 1'b0;
            br_imm   = 9'h003;       // must be ignored: latched copy is used
            pc_plus2 = 16'hAAAA;
            chk({name, ".stall"}, {31'd0, stall}, 1);
            chk({name, ".no_redirect"}, {31'd0, redirect}, 0);
            if (i == hold - 1) begin
                flag_pend = 1'b0;
                {N_flag, Z_flag, V_flag} = nzv;
            end
        end
        step();
        chk({name, ".stall_drop"}, {31'd0, stall}, 0);
        if (exp_taken) begin
            exp_cnt++;
            chk({name, ".redirect"}, {31'd0, redirect}, 1);
            chk({name, ".target"}, {16'd0, pc_target}, 32'h01E0);
        end else begin
            chk({name, ".redirect"}, {31'd0, redirect}, 0);
        end
        chk_cnt(name);
        step();
        chk({name, ".idle"}, {30'd0, redirect, stall}, 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".stall"}, {31'd0, stall}, 0);
        chk({name, ".redirect"}, {30'd0, redirect, flush}, 0);
        chk({name, ".target"}, {16'd0, pc_target}, 0);
        chk({name, ".cnt"}, {16'd0, taken_cnt}, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'b001, 9'h004, 16'h0000, 16'h0100, 3'b010, 1'b1, 16'h0108};
        vecs[1] = '{1'b0, 3'b000, 9'h004, 16'h0000, 16'h0100, 3'b010, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 3'b111, 9'h1FF, 16'h0000, 16'h0000, 3'b000, 1'b1, 16'hFFFE};
        vecs[3] = '{1'b1, 3'b111, 9'h0AA, 16'hBEEF, 16'h1234, 3'b000, 1'b1, 16'hBEEF};
        vecs[4] = '{1'b0, 3'b011, 9'h0FF, 16'h0000, 16'hFF00, 3'b100, 1'b1, 16'h00FE};
        vecs[5] = '{1'b1, 3'b110, 9'h000, 16'h1111, 16'h2222, 3'b110, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 3'b100, 9'h010, 16'h0000, 16'h4000, 3'b100, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 3'b101, 9'h100, 16'h0000, 16'h0300, 3'b010, 1'b1, 16'h0100};

        cmasks[0] = '{3'b000, 8'h33};
        cmasks[1] = '{3'b001, 8'hCC};
        cmasks[2] = '{3'b010, 8'h03};
        cmasks[3] = '{3'b011, 8'hF0};
        cmasks[4] = '{3'b100, 8'hCF};
        cmasks[5] = '{3'b101, 8'hFC};
        cmasks[6] = '{3'b110, 8'hAA};
        cmasks[7] = '{3'b111, 8'hFF};

        rst = 1'b1;
        br_valid = 1'b0; br_is_reg = 1'b0; br_cond = '0; br_imm = '0;
        br_reg = '0; pc_plus2 = '0; flag_pend = 1'b0;
        N_flag = 1'b0; Z_flag = 1'b0; V_flag = 1'b0;
        repeat (2) step();
        chk_zero("reset");
        rst = 1'b0;
        step();
        chk_zero("post_reset");

        for (int i = 0; i < 8; i++)
            do_branch($sformatf("vec%0d", i), vecs[i].is_reg, vecs[i].cond, vecs[i].imm,
                      vecs[i].breg, vecs[i].pc, vecs[i].nzv, vecs[i].exp_taken,
                      vecs[i].exp_target);

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                logic [7:0] m;
                m = cmasks[c].mask;
                do_branch($sformatf("cond%0d_nzv%0d", c, f), 1'b0, cmasks[c].cond,
                          9'h002, 16'h0000, 16'h1000, 3'(f), m[f], 16'h1004);
            end
        end

        hazard("haz_gt_taken", 3'b010, 3, 3'b000, 1'b1);
        hazard("haz_gt_z", 3'b010, 3, 3'b010, 1'b0);
        hazard("haz_un", 3'b111, 1, 3'b000, 1'b1);

        // Branch arriving during REDIRECT is wrong-path and must be ignored
        br_valid = 1'b1; br_is_reg = 1'b0; br_cond = 3'b111; br_imm = 9'h008;
        pc_plus2 = 16'h3000; flag_pend = 1'b0;
        step();
        exp_cnt++;
        chk("ign.first_redirect", {31'd0, redirect}, 1);
        pc_plus2 = 16'h7000;
        step();
        br_valid = 1'b0;
        chk("ign.redirect", {31'd0, redirect}, 0);
        chk("ign.target", {16'd0, pc_target}, 32'h3010);
        chk_cnt("ign");
        step();
        chk("ign.idle", {31'd0, redirect}, 0);

        // Asynchronous reset while in HOLD
        br_valid = 1'b1; br_cond = 3'b111; flag_pend = 1'b1;
        step();
        br_valid = 1'b0;
        chk("rst_hold.stall_before", {31'd0, stall}, 1);
        #2 rst = 1'b1;
        #1 chk_zero("rst_hold");
        exp_cnt = 0;
        flag_pend = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_hold.no_pulse", {30'd0, redirect, stall}, 0);
        end

        // Asynchronous reset while redirect is high
        br_valid = 1'b1; br_is_reg = 1'b1; br_cond = 3'b111; br_reg = 16'hCAFE;
        step();
        br_valid = 1'b0;
        chk("rst_redir.redirect_before", {31'd0, redirect}, 1);
        #2 rst = 1'b1;
        #1 chk_zero("rst_redir");
        step();
        rst = 1'b0;
        step();
        chk("rst_redir.no_pulse", {30'd0, redirect, flush}, 0);

        // 17 taken branches: 4-bit counter must stick at 4'hF
        for (int i = 0; i < 17; i++)
            do_branch($sformatf("sat%0d", i), 1'b1, 3'b111, 9'h000, 16'h0040,
                      16'h0000, 3'b000, 1'b1, 16'h0040);
        chk("sat.final4", {28'd0, taken_cnt4}, 32'hF);
        chk("sat.final16", {16'd0, taken_cnt}, 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
